// File: rtl/reg_alu_core_8bit.sv
// ---------------------------------------------------------------------------
// reg_alu_core_8bit
//
// Minimal single-cycle register/ALU datapath. Every rising clock edge executes
// one register-register instruction taken straight from the input fields:
// operands are read combinationally from the register file, the ALU result is
// written back to R[Rd], and the same result is captured on ALU_Result.
//
// Ports
//   clk         in   1  system clock, all state changes on the rising edge
//   rst         in   1  synchronous active-high reset (R[i] <= i, result <= 0)
//   Opcode      in   4  operation select (8..15 reserved: no write, result 0)
//   Rs          in   3  source register A index
//   Rt          in   3  source register B index (unused by NOT/SHL/SHR)
//   Rd          in   3  destination register index
//   ALU_Result  out  8  registered result of the last executed instruction
// ---------------------------------------------------------------------------
module reg_alu_core_8bit #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        Opcode,
  input  logic [2:0]        Rs,
  input  logic [2:0]        Rt,
  input  logic [2:0]        Rd,
  output logic [DATA_W-1:0] ALU_Result
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  // All arithmetic is unsigned modulo 2^DATA_W; carries and borrows are
  // dropped by the result width.
  function automatic logic [DATA_W-1:0] alu_f(input logic [2:0]        op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    case (alu_op_e'(op))
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SHL:  r = {a[DATA_W-2:0], 1'b0};
      OP_SHR:  r = {1'b0, a[DATA_W-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              op_vld;

  // Operand read: pre-edge register contents, so Rd aliasing Rs/Rt simply
  // uses the old value and overwrites it at the edge.
  assign opa    = regs_q[Rs];
  assign opb    = regs_q[Rt];
  // Upper half of the opcode space is reserved.
  assign op_vld = ~Opcode[3];

  always_comb begin
    result_d = '0;
    if (op_vld) begin
      result_d = alu_f(Opcode[2:0], opa, opb);
    end
  end

  // Execute / write-back edge. Reset discards any instruction on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
      result_q <= '0;
    end else begin
      if (op_vld) begin
        regs_q[Rd] <= result_d;
      end
      result_q <= result_d;
    end
  end

  assign ALU_Result = result_q;

endmodule

// File: tb/tb_reg_alu_core_8bit.sv
module tb_reg_alu_core_8bit;

  logic       clk;
  logic       rst;
  logic [3:0] Opcode;
  logic [2:0] Rs;
  logic [2:0] Rt;
  logic [2:0] Rd;
  logic [7:0] ALU_Result;

  int checks;
  int errors;

  reg_alu_core_8bit #(.DATA_W(8), .NREGS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .Opcode     (Opcode),
    .Rs         (Rs),
    .Rt         (Rt),
    .Rd         (Rd),
    .ALU_Result (ALU_Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic [3:0] op, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] rd,
                         input logic [7:0] exp, input string name);
    vec_t v;
    v.r = r; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    checks++;
    if (ALU_Result !== exp) begin
      errors++;
      $display("FAIL %s: ALU_Result=%02h expected=%02h", name, ALU_Result, exp);
    end
  endtask

  // Drive one instruction, take one edge, sample 1 time unit after it.
  task automatic step(input logic r, input logic [3:0] op, input logic [2:0] rs,
                      input logic [2:0] rt, input logic [2:0] rd);
    rst = r; Opcode = op; Rs = rs; Rt = rt; Rd = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; Opcode = 4'h0; Rs = 3'd0; Rt = 3'd0; Rd = 3'd0;

    // Reset held for two edges with a write-capable ADD presented (R7+R7 -> R0).
    add_vec(1, 4'h0, 3'd7, 3'd7, 3'd0, 8'h00, "rst_edge1");
    add_vec(1, 4'h0, 3'd7, 3'd7, 3'd0, 8'h00, "rst_edge2");
    // Read back every register through OR Ri,Ri,Ri (rewrites the same value).
    for (int i = 0; i < 8; i++) begin
      add_vec(0, 4'h3, 3'(i), 3'(i), 3'(i), 8'(i), $sformatf("rst_R%0d", i));
    end

    // Basic op sequence.
    add_vec(1, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, "seq_rst");
    add_vec(0, 4'h0, 3'd3, 3'd2, 3'd1, 8'h05, "seq_add");
    add_vec(0, 4'h1, 3'd3, 3'd2, 3'd1, 8'h01, "seq_sub");
    add_vec(0, 4'h2, 3'd1, 3'd2, 3'd0, 8'h00, "seq_and");
    add_vec(0, 4'h3, 3'd1, 3'd2, 3'd0, 8'h03, "seq_or");
    add_vec(0, 4'h4, 3'd1, 3'd2, 3'd0, 8'h03, "seq_xor");
    add_vec(0, 4'h5, 3'd1, 3'd6, 3'd0, 8'hFE, "seq_not");
    add_vec(0, 4'h6, 3'd1, 3'd6, 3'd0, 8'h02, "seq_shl");
    add_vec(0, 4'h7, 3'd1, 3'd6, 3'd0, 8'h00, "seq_shr");
    add_vec(0, 4'h3, 3'd0, 3'd0, 3'd2, 8'h00, "seq_r0_after_shr");
    add_vec(0, 4'h3, 3'd1, 3'd1, 3'd1, 8'h01, "seq_r1_final");

    // Wrap and boundaries.
    add_vec(1, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, "wrap_rst");
    add_vec(0, 4'h1, 3'd0, 3'd1, 3'd3, 8'hFF, "wrap_sub");
    add_vec(0, 4'h0, 3'd3, 3'd3, 3'd4, 8'hFE, "wrap_add");
    add_vec(0, 4'h6, 3'd3, 3'd0, 3'd5, 8'hFE, "wrap_shl");
    add_vec(0, 4'h7, 3'd3, 3'd0, 3'd6, 8'h7F, "wrap_shr");
    add_vec(0, 4'h0, 3'd4, 3'd6, 3'd2, 8'h7D, "wrap_r4_plus_r6");

    // Aliasing: Rd == Rs == Rt.
    add_vec(1, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, "alias_rst");
    add_vec(0, 4'h0, 3'd7, 3'd7, 3'd7, 8'h0E, "alias_add1");
    add_vec(0, 4'h0, 3'd7, 3'd7, 3'd7, 8'h1C, "alias_add2");
    add_vec(0, 4'h0, 3'd7, 3'd7, 3'd7, 8'h38, "alias_add3");

    // Reserved opcodes must not write.
    add_vec(1, 4'h0, 3'd0, 3'd0, 3'd0, 8'h00, "rsv_rst");
    add_vec(0, 4'hA, 3'd7, 3'd7, 3'd2, 8'h00, "rsv_1010");
    add_vec(0, 4'h3, 3'd2, 3'd2, 3'd0, 8'h02, "rsv_r2_kept");
    add_vec(0, 4'hF, 3'd7, 3'd6, 3'd3, 8'h00, "rsv_1111");
    add_vec(0, 4'h8, 3'd7, 3'd6, 3'd3, 8'h00, "rsv_1000");
    add_vec(0, 4'h3, 3'd3, 3'd3, 3'd0, 8'h03, "rsv_r3_kept");

    foreach (vecs[k]) begin
      step(vecs[k].r, vecs[k].op, vecs[k].rs, vecs[k].rt, vecs[k].rd);
      check(vecs[k].name, vecs[k].exp);
    end

    // Mid-stream reset: dirty some registers, reset with ADD 3,2,1 presented.
    step(0, 4'h0, 3'd7, 3'd7, 3'd3);   // R3 = 0E
    step(0, 4'h5, 3'd2, 3'd0, 3'd2);   // R2 = FD
    check("mid_dirty", 8'hFD);
    step(1, 4'h0, 3'd3, 3'd2, 3'd1);
    check("mid_rst", 8'h00);
    step(0, 4'h0, 3'd3, 3'd2, 3'd1);
    check("mid_add_after_rst", 8'h05);

    // Output is registered: changing inputs between edges must not move it.
    rst = 1'b0; Opcode = 4'h5; Rs = 3'd0; Rt = 3'd0; Rd = 3'd0;
    #2;
    check("hold_between_edges", 8'h05);
    @(posedge clk);
    #1;
    check("not_r0_after_edge", 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
